// File: rtl/des_pkg.sv
// DES tables, FSM state encoding and permutation helpers shared by the
// decrypt core and its Feistel round function. Bit 1 in FIPS numbering is [63].
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9,  1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41, 9,  49, 17, 57, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,
        1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27,
        19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
        7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29,
        21, 13, 5,  28, 20, 12, 4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,
        3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,
        16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int E_T [48] = '{
        32, 1,  2,  3,  4,  5,
        4,  5,  6,  7,  8,  9,
        8,  9,  10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32, 1
    };

    localparam int P_T [32] = '{
        16, 7,  20, 21, 29, 12, 28, 17,
        1,  15, 23, 26, 5,  18, 31, 10,
        2,  8,  24, 14, 32, 27, 3,  9,
        19, 13, 30, 6,  22, 11, 4,  25
    };

    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
    };

    // Right-rotation applied to CD after round n (index n = 1..15), i.e.
    // the encrypt left shift of round 17-n undone. Index 0 is unused.
    localparam int DEC_ROT [16] = '{
        0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Each helper walks its table MSB-first, shifting the picked bit in.
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y = {y[62:0], x[6'(64 - IP_T[6'(i)])]};
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y = {y[62:0], x[6'(64 - FP_T[6'(i)])]};
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++)
            y = {y[54:0], x[6'(64 - PC1_T[6'(i)])]};
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++)
            y = {y[46:0], x[6'(56 - PC2_T[6'(i)])]};
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++)
            y = {y[46:0], x[5'(32 - E_T[6'(i)])]};
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++)
            y = {y[30:0], x[5'(32 - P_T[5'(i)])]};
        return y;
    endfunction

    // Row comes from the outer bits of each 6-bit group, column from the
    // inner four, so {b5,b0,b4..b1} is the flat table index.
    function automatic logic [31:0] sbox_sub(input logic [47:0] x);
        logic [47:0] t;
        logic [5:0]  b;
        logic [31:0] y;
        t = x;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            b = t[47:42];
            t = t << 6;
            y = {y[27:0], 4'(SBOX[3'(i)][{b[5], b[0], b[4:1]}])};
        end
        return y;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] h,
                                           input logic [1:0]  amt);
        return (amt == 2'd2) ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

endpackage

// File: rtl/feistel_function.sv
// DES Feistel function f(R, K): E-expansion, key XOR, S-boxes, P.
// Ports: round_key (48b subkey), feistel_input (R half), feistel_output (f).
module feistel_function
    import des_pkg::*;
(
    input  logic [47:0] round_key,
    input  logic [31:0] feistel_input,
    output logic [31:0] feistel_output
);

    logic [47:0] mixed;

    assign mixed          = e_expand(feistel_input) ^ round_key;
    assign feistel_output = p_perm(sbox_sub(mixed));

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryptor: one round per cycle on a single Feistel instance.
// Ports: clk, rst (sync high), in_valid/in_ready + key_i/data_i in,
// out_valid/out_ready + data_o out, busy while rounds run.
module des_decrypt_core
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] key_i,
    input  logic [63:0] data_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_o,
    output logic        busy
);

    state_t      state;
    logic [63:0] lr;
    logic [55:0] cd;
    logic [4:0]  cnt;
    logic [47:0] sub_key;
    logic [31:0] f_out;
    logic [1:0]  rot;

    assign sub_key = pc2_perm(cd);
    assign rot     = 2'(DEC_ROT[cnt[3:0]]);

    feistel_function u_feistel (
        .round_key      (sub_key),
        .feistel_input  (lr[31:0]),
        .feistel_output (f_out)
    );

    // cnt 1..16 run the rounds; cnt 17 applies FP, giving a 17-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            data_o    <= '0;
            cnt       <= '0;
            lr        <= '0;
            cd        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        lr       <= ip_perm(data_i);
                        cd       <= pc1_perm(key_i);
                        cnt      <= 5'd1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ROUND;
                    end
                end
                ROUND: begin
                    if (cnt != 5'd17) begin
                        lr <= {lr[31:0], lr[63:32] ^ f_out};
                        // No rotation after round 16: CD is no longer used.
                        if (cnt < 5'd16)
                            cd <= {rotr28(cd[55:28], rot),
                                   rotr28(cd[27:0], rot)};
                        cnt <= cnt + 5'd1;
                    end else begin
                        // Final swap: preoutput is R16 || L16.
                        data_o    <= fp_perm({lr[31:0], lr[63:32]});
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_core.sv
// Scoreboard bench for des_decrypt_core: directed KATs, backpressure,
// mid-run reset, back-to-back blocks and input churn.
module tb_des_decrypt_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] key_i = '0;
    logic [63:0] data_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] data_o;
    logic        busy;

    des_decrypt_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_i     (key_i),
        .data_i    (data_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] C2 = 64'h0000000000000000;
    localparam logic [63:0] P2 = 64'h8787878787878787;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_hs = 0;
    logic [63:0] exp_q[$];
    int          hs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    logic prev_ov = 1'b0;
    int   rise = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            check("exclusive", 64'($countones({in_ready, busy, out_valid})),
                  64'd1);
            if (out_valid && !prev_ov) rise = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %h required none",
                             data_o);
                end else begin
                    check("data", data_o, exp_q.pop_front());
                    check("latency", 64'(rise - hs_q.pop_front()), 64'd17);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input logic [63:0] key, input logic [63:0] data,
                        input logic [63:0] expv);
        int n;
        @(negedge clk);
        key_i = key;
        data_i = data;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(expv);
            @(posedge clk);
            #1;
            hs_q.push_back(cyc);
            last_hs = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
            hs_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] held;
        int hs_a, hs_b, hs_c, n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_o", data_o, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        send(K1, C1, P1);
        drain();
        send(K2, C2, P2);
        drain();

        // Backpressure
        out_ready = 1'b0;
        send(K1, C1, P1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", 64'(out_valid), 64'd1);
        held = data_o;
        repeat (10) begin
            @(negedge clk);
            check("bp_hold", data_o, held);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release", 64'(in_ready), 64'd1);
        drain();

        // Mid-run reset after round 8
        send(K1, C1, P1);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        hs_q.delete();
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        send(K1, C1, P1);
        drain();

        // Back-to-back
        send(K1, C1, P1);
        hs_a = last_hs;
        send(K2, C2, P2);
        hs_b = last_hs;
        send(K1, C1, P1);
        hs_c = last_hs;
        check("b2b_gap1", 64'(hs_b - hs_a), 64'd19);
        check("b2b_gap2", 64'(hs_c - hs_b), 64'd19);
        drain();

        // Input churn during rounds
        send(K2, C2, P2);
        repeat (10) begin
            @(negedge clk);
            key_i = {$urandom, $urandom};
            data_i = {$urandom, $urandom};
            in_valid = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        drain();
        repeat (3) begin
            @(negedge clk);
            check("churn_idle_ready", 64'(in_ready), 64'd1);
            check("churn_idle_busy", 64'(busy), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
